multicycle_ctrl: RTL and testbench

Multicycle MIPS control unit: a Moore/Mealy FSM that sequences each instruction through fetch, decode, execute, memory and writeback, and drives the datapath muxes, write enables and the ALU `sel` input. It sits directly upstream of the ALU. It consumes the ALU's `zero`, `overflow` and `ge_than_zero` flags for branches and add-overflow trapping. Memory accesses use a ready handshake so the FSM stalls on slow memory.

---
 rtl/multicycle_ctrl_pkg.sv | 78 +++++++
 rtl/multicycle_ctrl_if.sv | 43 ++++
 rtl/multicycle_ctrl_alu_funct_dec.sv | 24 ++
 rtl/multicycle_ctrl.sv | 150 +++++++++++++++
 tb/tb_multicycle_ctrl.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// multicycle_ctrl_pkg
// Shared encodings for the multicycle MIPS control unit: FSM state type,
// ALU select codes, datapath mux encodings, opcode/funct values and the
// DECODE-state dispatch function.
package multicycle_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC_R   = 4'd3,
        S_EXEC_I   = 4'd4,
        S_MEM_ADDR = 4'd5,
        S_MEM_RD   = 4'd6,
        S_MEM_WB   = 4'd7,
        S_MEM_WR   = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10,
        S_ALU_WB   = 4'd11,
        S_HALT     = 4'd12
    } state_t;

    localparam logic [1:0] ALU_SEL_ADD = 2'd0;
    localparam logic [1:0] ALU_SEL_SUB = 2'd1;
    localparam logic [1:0] ALU_SEL_OR  = 2'd2;
    localparam logic [1:0] ALU_SEL_SLT = 2'd3;

    localparam logic [1:0] SRC_A_PC   = 2'd0;
    localparam logic [1:0] SRC_A_REG  = 2'd1;
    localparam logic [1:0] SRC_A_ZERO = 2'd2;

    localparam logic [2:0] SRC_B_REG     = 3'd0;
    localparam logic [2:0] SRC_B_FOUR    = 3'd1;
    localparam logic [2:0] SRC_B_SEXT    = 3'd2;
    localparam logic [2:0] SRC_B_SEXT_SH = 3'd3;
    localparam logic [2:0] SRC_B_ZEXT    = 3'd4;
    localparam logic [2:0] SRC_B_UPPER   = 3'd5;
    localparam logic [2:0] SRC_B_ZERO    = 3'd6;

    localparam logic [1:0] PC_SRC_ALU    = 2'd0;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_ORI    = 6'h0D;
    localparam logic [5:0] OP_LUI    = 6'h0F;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SW     = 6'h2B;

    localparam logic [4:0] RT_BGEZ = 5'd1;

    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    // Successor of DECODE; unsupported opcodes fall into HALT.
    function automatic state_t decode_next(input logic [5:0] opcode, input logic [4:0] rt);
        state_t nxt;
        nxt = S_HALT;
        case (opcode)
            OP_RTYPE:       nxt = S_EXEC_R;
            OP_ORI, OP_LUI: nxt = S_EXEC_I;
            OP_LW, OP_SW:   nxt = S_MEM_ADDR;
            OP_BEQ:         nxt = S_BRANCH;
            OP_REGIMM:      nxt = (rt == RT_BGEZ) ? S_BRANCH : S_HALT;
            OP_J:           nxt = S_JUMP;
            default:        nxt = S_HALT;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if
// Controller <-> datapath bundle.
//   master: the control unit (reads IR fields, ALU flags, mem_ready;
//           drives mux selects, write enables, trap/halt status)
//   slave : the datapath/memory side (the reverse)
interface multicycle_ctrl_if;
    import multicycle_ctrl_pkg::*;

    logic [5:0] opcode;
    logic [5:0] funct;
    logic [4:0] rt;
    logic       alu_zero;
    logic       alu_overflow;
    logic       alu_ge_zero;
    logic       mem_ready;

    logic [1:0] alu_sel;
    logic [1:0] alu_src_a;
    logic [2:0] alu_src_b;
    logic       pc_we;
    logic [1:0] pc_src;
    logic       ir_we;
    logic       mem_re;
    logic       mem_we;
    logic       iord;
    logic       reg_we;
    logic       reg_dst;
    logic       wb_src;
    logic       ovf_trap;
    logic       halted;

    modport master (
        input  opcode, funct, rt, alu_zero, alu_overflow, alu_ge_zero, mem_ready,
        output alu_sel, alu_src_a, alu_src_b, pc_we, pc_src, ir_we, mem_re,
               mem_we, iord, reg_we, reg_dst, wb_src, ovf_trap, halted
    );

    modport slave (
        output opcode, funct, rt, alu_zero, alu_overflow, alu_ge_zero, mem_ready,
        input  alu_sel, alu_src_a, alu_src_b, pc_we, pc_src, ir_we, mem_re,
               mem_we, iord, reg_we, reg_dst, wb_src, ovf_trap, halted
    );
endinterface

// File: rtl/multicycle_ctrl_alu_funct_dec.sv
// alu_funct_dec
// Combinational R-type funct decoder.
//   funct   in  6  IR[5:0]
//   alu_sel out 2  ALU operation for the funct
//   illegal out 1  funct not supported by this core
module alu_funct_dec
    import multicycle_ctrl_pkg::*;
(
    input  logic [5:0] funct,
    output logic [1:0] alu_sel,
    output logic       illegal
);
    always_comb begin
        alu_sel = ALU_SEL_ADD;
        illegal = 1'b0;
        case (funct)
            FN_ADD, FN_ADDU: alu_sel = ALU_SEL_ADD;
            FN_SUB, FN_SUBU: alu_sel = ALU_SEL_SUB;
            FN_OR:           alu_sel = ALU_SEL_OR;
            FN_SLT:          alu_sel = ALU_SEL_SLT;
            default:         illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
// Multicycle MIPS control FSM. Sequences fetch/decode/execute/memory/
// writeback and drives datapath controls. Outputs decode combinationally
// from state; pc_we/ir_we in FETCH and pc_we in BRANCH also follow inputs.
//   clk in  system clock, rising edge
//   rst in  asynchronous active-high reset
//   bus     multicycle_ctrl_if.master (IR fields, ALU flags, mem_ready in;
//           mux selects, enables, ovf_trap, halted out)
//
// state    | meaning
// IDLE     | post-reset, all outputs low
// FETCH    | read instruction at PC, PC+4, wait mem_ready
// DECODE   | branch target into ALUOut, dispatch on opcode
// EXEC_R   | R-type ALU op, latch add overflow
// EXEC_I   | ori / lui ALU op
// MEM_ADDR | lw/sw effective address
// MEM_RD   | data read, wait mem_ready
// MEM_WB   | MDR to rt
// MEM_WR   | data write, wait mem_ready
// BRANCH   | beq / bgez compare, conditional PC load
// JUMP     | PC <- jump target
// ALU_WB   | ALUOut to rd/rt unless add overflowed
// HALT     | stopped until reset
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    multicycle_ctrl_if.master bus
);
    state_t     state;
    logic       ovf_q;
    logic       reg_dst_q;
    logic [1:0] r_sel;
    logic       r_illegal;

    alu_funct_dec u_funct_dec (
        .funct   (bus.funct),
        .alu_sel (r_sel),
        .illegal (r_illegal)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            ovf_q     <= 1'b0;
            reg_dst_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE:     state <= S_FETCH;
                S_FETCH:    if (bus.mem_ready) state <= S_DECODE;
                S_DECODE:   state <= decode_next(bus.opcode, bus.rt);
                S_EXEC_R: begin
                    // Only signed add traps; sub is treated as subu.
                    ovf_q     <= bus.alu_overflow & (bus.funct == FN_ADD);
                    reg_dst_q <= 1'b1;
                    state     <= r_illegal ? S_HALT : S_ALU_WB;
                end
                S_EXEC_I: begin
                    ovf_q     <= 1'b0;
                    reg_dst_q <= 1'b0;
                    state     <= S_ALU_WB;
                end
                S_ALU_WB:   state <= S_FETCH;
                S_MEM_ADDR: state <= (bus.opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
                S_MEM_RD:   if (bus.mem_ready) state <= S_MEM_WB;
                S_MEM_WB:   state <= S_FETCH;
                S_MEM_WR:   if (bus.mem_ready) state <= S_FETCH;
                S_BRANCH:   state <= S_FETCH;
                S_JUMP:     state <= S_FETCH;
                S_HALT:     state <= S_HALT;
                default:    state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.alu_sel   = ALU_SEL_ADD;
        bus.alu_src_a = SRC_A_PC;
        bus.alu_src_b = SRC_B_REG;
        bus.pc_we     = 1'b0;
        bus.pc_src    = PC_SRC_ALU;
        bus.ir_we     = 1'b0;
        bus.mem_re    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.iord      = 1'b0;
        bus.reg_we    = 1'b0;
        bus.reg_dst   = 1'b0;
        bus.wb_src    = 1'b0;
        bus.ovf_trap  = 1'b0;
        bus.halted    = 1'b0;
        case (state)
            S_FETCH: begin
                bus.mem_re    = 1'b1;
                bus.alu_src_b = SRC_B_FOUR;
                bus.ir_we     = bus.mem_ready;
                bus.pc_we     = bus.mem_ready;
            end
            S_DECODE: bus.alu_src_b = SRC_B_SEXT_SH;
            S_EXEC_R: begin
                bus.alu_sel   = r_sel;
                bus.alu_src_a = SRC_A_REG;
            end
            S_EXEC_I: begin
                bus.alu_sel   = ALU_SEL_OR;
                bus.alu_src_a = (bus.opcode == OP_LUI) ? SRC_A_ZERO : SRC_A_REG;
                bus.alu_src_b = (bus.opcode == OP_LUI) ? SRC_B_UPPER : SRC_B_ZEXT;
            end
            S_ALU_WB: begin
                bus.reg_we   = ~ovf_q;
                bus.ovf_trap = ovf_q;
                bus.reg_dst  = reg_dst_q;
            end
            S_MEM_ADDR: begin
                bus.alu_src_a = SRC_A_REG;
                bus.alu_src_b = SRC_B_SEXT;
            end
            S_MEM_RD: begin
                bus.mem_re = 1'b1;
                bus.iord   = 1'b1;
            end
            S_MEM_WB: begin
                bus.reg_we = 1'b1;
                bus.wb_src = 1'b1;
            end
            S_MEM_WR: begin
                bus.mem_we = 1'b1;
                bus.iord   = 1'b1;
            end
            S_BRANCH: begin
                bus.alu_sel   = ALU_SEL_SUB;
                bus.alu_src_a = SRC_A_REG;
                bus.pc_src    = PC_SRC_ALUOUT;
                if (bus.opcode == OP_BEQ) begin
                    bus.alu_src_b = SRC_B_REG;
                    bus.pc_we     = bus.alu_zero;
                end else begin
                    bus.alu_src_b = SRC_B_ZERO;
                    bus.pc_we     = bus.alu_ge_zero;
                end
            end
            S_JUMP: begin
                bus.pc_we  = 1'b1;
                bus.pc_src = PC_SRC_JUMP;
            end
            S_HALT:  bus.halted = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;
    import multicycle_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_pass = 0;

    multicycle_ctrl_if bus ();

    multicycle_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // Control word: {sel,a,b,pc_we,pc_src,ir_we,mem_re,mem_we,iord,reg_we,reg_dst,wb_src,trap,halt}
    function automatic logic [18:0] cw(input logic [1:0] sel, input logic [1:0] a,
                                       input logic [2:0] b, input logic pcwe,
                                       input logic [1:0] pcsrc, input logic irwe, re, we,
                                       iord, regwe, regdst, wbsrc, trap, halt);
        return {sel, a, b, pcwe, pcsrc, irwe, re, we, iord, regwe, regdst, wbsrc, trap, halt};
    endfunction

    function automatic logic [18:0] act_cw();
        return {bus.alu_sel, bus.alu_src_a, bus.alu_src_b, bus.pc_we, bus.pc_src,
                bus.ir_we, bus.mem_re, bus.mem_we, bus.iord, bus.reg_we, bus.reg_dst,
                bus.wb_src, bus.ovf_trap, bus.halted};
    endfunction

    // Inputs are set at posedge+1; checks happen at posedge+2, then advance.
    task automatic cyc(input string tag, input state_t st, input logic [18:0] exp);
        #1;
        chk({tag, ".st"}, 32'(dut.state), 32'(st));
        chk({tag, ".cw"}, 32'(act_cw()), 32'(exp));
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cyc("rst_idle", S_IDLE, '0);
    endtask

    task automatic set_ir(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] r);
        bus.opcode = op;
        bus.funct  = fn;
        bus.rt     = r;
    endtask

    logic [18:0] w_fetch, w_dec, w_xr, w_wb_rd, w_wb_rt, w_wb_trap, w_rd, w_wr, w_halt;

    initial begin
        w_fetch   = cw(ALU_SEL_ADD, 0, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        w_dec     = cw(ALU_SEL_ADD, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        w_xr      = cw(ALU_SEL_ADD, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        w_wb_rd   = cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        w_wb_rt   = cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        w_wb_trap = cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
        w_rd      = cw(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0);
        w_wr      = cw(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        w_halt    = cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

        rst = 1'b1;
        set_ir(6'h00, 6'h20, 5'd0);
        bus.alu_zero = 1'b0;
        bus.alu_overflow = 1'b0;
        bus.alu_ge_zero = 1'b0;
        bus.mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        chk("reset.st", 32'(dut.state), 32'(S_IDLE));
        chk("reset.cw", 32'(act_cw()), 32'h0);
        rst = 1'b0;
        cyc("rel_idle", S_IDLE, '0);

        // add, no overflow
        cyc("add.f", S_FETCH, w_fetch);
        cyc("add.d", S_DECODE, w_dec);
        cyc("add.x", S_EXEC_R, w_xr);
        cyc("add.wb", S_ALU_WB, w_wb_rd);

        // add with overflow: writeback suppressed
        bus.alu_overflow = 1'b1;
        cyc("addv.f", S_FETCH, w_fetch);
        cyc("addv.d", S_DECODE, w_dec);
        cyc("addv.x", S_EXEC_R, w_xr);
        cyc("addv.wb", S_ALU_WB, w_wb_trap);

        // ori right after a trap: EXEC_I clears the latch
        set_ir(OP_ORI, 6'h00, 5'd3);
        cyc("ori.f", S_FETCH, w_fetch);
        cyc("ori.d", S_DECODE, w_dec);
        cyc("ori.x", S_EXEC_I, cw(ALU_SEL_OR, 1, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        cyc("ori.wb", S_ALU_WB, w_wb_rt);

        // addu / sub with overflow flag set: no trap
        set_ir(OP_RTYPE, FN_ADDU, 5'd0);
        cyc("addu.f", S_FETCH, w_fetch);
        cyc("addu.d", S_DECODE, w_dec);
        cyc("addu.x", S_EXEC_R, w_xr);
        cyc("addu.wb", S_ALU_WB, w_wb_rd);
        set_ir(OP_RTYPE, FN_SUB, 5'd0);
        cyc("sub.f", S_FETCH, w_fetch);
        cyc("sub.d", S_DECODE, w_dec);
        cyc("sub.x", S_EXEC_R, cw(ALU_SEL_SUB, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        cyc("sub.wb", S_ALU_WB, w_wb_rd);
        bus.alu_overflow = 1'b0;
        set_ir(OP_RTYPE, FN_SLT, 5'd0);
        cyc("slt.f", S_FETCH, w_fetch);
        cyc("slt.d", S_DECODE, w_dec);
        cyc("slt.x", S_EXEC_R, cw(ALU_SEL_SLT, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        cyc("slt.wb", S_ALU_WB, w_wb_rd);
        set_ir(OP_RTYPE, FN_OR, 5'd0);
        cyc("or.f", S_FETCH, w_fetch);
        cyc("or.d", S_DECODE, w_dec);
        cyc("or.x", S_EXEC_R, cw(ALU_SEL_OR, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        cyc("or.wb", S_ALU_WB, w_wb_rd);
        set_ir(OP_LUI, 6'h00, 5'd0);
        cyc("lui.f", S_FETCH, w_fetch);
        cyc("lui.d", S_DECODE, w_dec);
        cyc("lui.x", S_EXEC_I, cw(ALU_SEL_OR, 2, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        cyc("lui.wb", S_ALU_WB, w_wb_rt);

        // lw with a fetch stall and two MEM_RD stall cycles
        set_ir(OP_LW, 6'h00, 5'd0);
        bus.mem_ready = 1'b0;
        cyc("lw.fs", S_FETCH, cw(ALU_SEL_ADD, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        bus.mem_ready = 1'b1;
        cyc("lw.f", S_FETCH, w_fetch);
        bus.mem_ready = 1'b0;
        cyc("lw.d", S_DECODE, w_dec);
        cyc("lw.a", S_MEM_ADDR, cw(ALU_SEL_ADD, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        cyc("lw.r0", S_MEM_RD, w_rd);
        cyc("lw.r1", S_MEM_RD, w_rd);
        bus.mem_ready = 1'b1;
        cyc("lw.r2", S_MEM_RD, w_rd);
        bus.mem_ready = 1'b0;
        cyc("lw.wb", S_MEM_WB, cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0));
        bus.mem_ready = 1'b1;

        // sw, zero wait
        set_ir(OP_SW, 6'h00, 5'd0);
        cyc("sw.f", S_FETCH, w_fetch);
        cyc("sw.d", S_DECODE, w_dec);
        cyc("sw.a", S_MEM_ADDR, cw(ALU_SEL_ADD, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        cyc("sw.w", S_MEM_WR, w_wr);

        // beq taken / not taken; ge flag set opposite to catch a wrong mux
        set_ir(OP_BEQ, 6'h00, 5'd0);
        bus.alu_zero = 1'b1;
        bus.alu_ge_zero = 1'b0;
        cyc("beqt.f", S_FETCH, w_fetch);
        cyc("beqt.d", S_DECODE, w_dec);
        cyc("beqt.b", S_BRANCH, cw(ALU_SEL_SUB, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        bus.alu_zero = 1'b0;
        bus.alu_ge_zero = 1'b1;
        cyc("beqn.f", S_FETCH, w_fetch);
        cyc("beqn.d", S_DECODE, w_dec);
        cyc("beqn.b", S_BRANCH, cw(ALU_SEL_SUB, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        // bgez taken / not taken
        set_ir(OP_REGIMM, 6'h00, 5'd1);
        cyc("bgzt.f", S_FETCH, w_fetch);
        cyc("bgzt.d", S_DECODE, w_dec);
        cyc("bgzt.b", S_BRANCH, cw(ALU_SEL_SUB, 1, 6, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        bus.alu_zero = 1'b1;
        bus.alu_ge_zero = 1'b0;
        cyc("bgzn.f", S_FETCH, w_fetch);
        cyc("bgzn.d", S_DECODE, w_dec);
        cyc("bgzn.b", S_BRANCH, cw(ALU_SEL_SUB, 1, 6, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        // j
        set_ir(OP_J, 6'h00, 5'd0);
        cyc("j.f", S_FETCH, w_fetch);
        cyc("j.d", S_DECODE, w_dec);
        cyc("j.j", S_JUMP, cw(0, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        // sw stalled in MEM_WR, reset mid-access
        set_ir(OP_SW, 6'h00, 5'd0);
        cyc("swr.f", S_FETCH, w_fetch);
        cyc("swr.d", S_DECODE, w_dec);
        bus.mem_ready = 1'b0;
        cyc("swr.a", S_MEM_ADDR, cw(ALU_SEL_ADD, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        chk("swr.w", 32'(act_cw()), 32'(w_wr));
        rst = 1'b1;
        #1;
        chk("swr.rst_we", 32'(bus.mem_we), 32'h0);
        chk("swr.rst_st", 32'(dut.state), 32'(S_IDLE));
        tick();
        rst = 1'b0;
        bus.mem_ready = 1'b1;
        cyc("swr.idle", S_IDLE, '0);

        // bgez encoding with rt=0 is unsupported
        set_ir(OP_REGIMM, 6'h00, 5'd0);
        cyc("bgz0.f", S_FETCH, w_fetch);
        cyc("bgz0.d", S_DECODE, w_dec);
        cyc("bgz0.h", S_HALT, w_halt);
        do_reset();

        // illegal R-type funct
        set_ir(OP_RTYPE, 6'h00, 5'd0);
        cyc("ilf.f", S_FETCH, w_fetch);
        cyc("ilf.d", S_DECODE, w_dec);
        tick();
        cyc("ilf.h", S_HALT, w_halt);
        do_reset();

        // unknown opcode: HALT is absorbing regardless of inputs
        set_ir(6'h3F, 6'h20, 5'd1);
        cyc("op3f.f", S_FETCH, w_fetch);
        cyc("op3f.d", S_DECODE, w_dec);
        for (int i = 0; i < 10; i++) begin
            bus.mem_ready = i[0];
            cyc($sformatf("op3f.h%0d", i), S_HALT, w_halt);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
